dev_bus_arbiter: RTL and testbench

DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

---
 rtl/dev_bus_pkg.sv | 24 ++
 rtl/dev_arb_pick.sv | 41 ++++
 rtl/dev_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_dev_bus_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dev_bus_pkg.sv
// ============================================================================
// dev_bus_pkg : shared arbiter state encoding and master index constants
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dev_bus_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_own0 = 2'd1;
  localparam logic [1:0] c_st_own1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_st_idle,
    ST_OWN0 = c_st_own0,
    ST_OWN1 = c_st_own1
  } arb_state_e;

  localparam logic c_m0 = 1'b0;
  localparam logic c_m1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dev_arb_pick.sv
// ============================================================================
// dev_arb_pick : combinational next-owner decision for dev_bus_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dev_arb_pick
  import dev_bus_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  arb_state_e i_cur,
  input  logic       i_hold_expired,
  input  logic       i_prio,
  output arb_state_e o_next
);

  logic w_tie_pick;

  always_comb begin
    // An owner that has used up its hold budget yields to the waiting master.
    w_tie_pick = i_prio;
    if (i_hold_expired && (i_cur == ST_OWN0)) begin
      w_tie_pick = c_m1;
    end else if (i_hold_expired && (i_cur == ST_OWN1)) begin
      w_tie_pick = c_m0;
    end

    o_next = ST_IDLE;
    if (i_req0 && i_req1) begin
      o_next = (w_tie_pick == c_m1) ? ST_OWN1 : ST_OWN0;
    end else if (i_req0) begin
      o_next = ST_OWN0;
    end else if (i_req1) begin
      o_next = ST_OWN1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dev_bus_arbiter.sv
// ============================================================================
// dev_bus_arbiter : two-master arbiter in front of the devctrl bus.
// Define DEV_ARB_ROUND_ROBIN_EN for round-robin ties; default is m0 priority.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0Enable_i,
  input  logic        m0Write_i,
  input  logic [31:0] m0Addr_i,
  input  logic [31:0] m0DataSave_i,
  input  logic [3:0]  m0ByteSelect_i,
  output logic [31:0] m0DataLoad_o,
  output logic        m0Busy_o,

  input  logic        m1Enable_i,
  input  logic        m1Write_i,
  input  logic [31:0] m1Addr_i,
  input  logic [31:0] m1DataSave_i,
  input  logic [3:0]  m1ByteSelect_i,
  output logic [31:0] m1DataLoad_o,
  output logic        m1Busy_o,

  output logic        devEnable_o,
  output logic        devWrite_o,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  output logic [3:0]  devByteSelect_o,
  input  logic [31:0] devDataLoad_i,
  input  logic        devBusy_i
);

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  arb_state_e state_q, state_d, w_pick_state;
  logic [7:0] hold_q, hold_d, w_hold_cnt;
  logic       w_own0, w_own1;
  logic       w_completion, w_owner_dropped, w_rearb;
  logic       w_other_en, w_hold_expired, w_prio;

`ifdef DEV_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
`endif

  assign w_own0 = (state_q == ST_OWN0);
  assign w_own1 = (state_q == ST_OWN1);

  always_comb begin
    devEnable_o       = 1'b0;
    devWrite_o        = 1'b0;
    devPhysicalAddr_o = '0;
    devDataSave_o     = '0;
    devByteSelect_o   = '0;
    case (state_q)
      ST_OWN0: begin
        devEnable_o       = m0Enable_i;
        devWrite_o        = m0Write_i;
        devPhysicalAddr_o = m0Addr_i;
        devDataSave_o     = m0DataSave_i;
        devByteSelect_o   = m0ByteSelect_i;
      end
      ST_OWN1: begin
        devEnable_o       = m1Enable_i;
        devWrite_o        = m1Write_i;
        devPhysicalAddr_o = m1Addr_i;
        devDataSave_o     = m1DataSave_i;
        devByteSelect_o   = m1ByteSelect_i;
      end
      default: ;
    endcase
  end

  assign m0Busy_o     = m0Enable_i & ~(w_own0 & ~devBusy_i);
  assign m1Busy_o     = m1Enable_i & ~(w_own1 & ~devBusy_i);
  assign m0DataLoad_o = w_own0 ? devDataLoad_i : '0;
  assign m1DataLoad_o = w_own1 ? devDataLoad_i : '0;

  always_comb begin
    // devBusy_i reaches the next state only through this completion term.
    w_completion    = ((w_own0 & m0Enable_i) | (w_own1 & m1Enable_i)) & ~devBusy_i;
    w_owner_dropped = (w_own0 & ~m0Enable_i) | (w_own1 & ~m1Enable_i);
    w_rearb         = w_completion | w_owner_dropped | (state_q == ST_IDLE);
    w_other_en      = w_own0 ? m1Enable_i : (w_own1 ? m0Enable_i : 1'b0);

    // Count including this cycle's completion so the limit bites on the Nth one.
    w_hold_cnt = hold_q;
    if (!w_other_en) begin
      w_hold_cnt = '0;
    end else if (w_completion && (hold_q != 8'hFF)) begin
      w_hold_cnt = hold_q + 8'd1;
    end
    w_hold_expired = w_other_en && (w_hold_cnt >= c_max_hold);
  end

`ifdef DEV_ARB_ROUND_ROBIN_EN
  assign w_prio = rr_q;
`else
  assign w_prio = c_m0;
`endif

  dev_arb_pick u_pick (
    .i_req0         (m0Enable_i),
    .i_req1         (m1Enable_i),
    .i_cur          (state_q),
    .i_hold_expired (w_hold_expired),
    .i_prio         (w_prio),
    .o_next         (w_pick_state)
  );

  always_comb begin
    state_d = w_rearb ? w_pick_state : state_q;
    hold_d  = (state_d != state_q) ? 8'd0 : w_hold_cnt;
`ifdef DEV_ARB_ROUND_ROBIN_EN
    rr_d = rr_q;
    if (w_rearb && (state_d == ST_OWN0)) begin
      rr_d = c_m1;
    end else if (w_rearb && (state_d == ST_OWN1)) begin
      rr_d = c_m0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
`ifdef DEV_ARB_ROUND_ROBIN_EN
      rr_q    <= c_m0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
`ifdef DEV_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dev_bus_arbiter.sv
// ============================================================================
// tb_dev_bus_arbiter : directed self-checking bench for dev_bus_arbiter
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_dev_bus_arbiter;

  localparam int          MAX_HOLD = 4;
  localparam logic [31:0] c_a0 = 32'h8000_0010;
  localparam logic [31:0] c_a1 = 32'h4000_0200;
  localparam logic [31:0] c_d0 = 32'h1111_0000;
  localparam logic [31:0] c_d1 = 32'h2222_0000;
  localparam logic [3:0]  c_b0 = 4'hF;
  localparam logic [3:0]  c_b1 = 4'h3;
  localparam logic [31:0] c_rd = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_en = 1'b0, m1_en = 1'b0, dev_busy = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, dev_addr, dev_wdata;
  logic        m0_busy, m1_busy, dev_en, dev_wr;
  logic [3:0]  dev_be;

  int checks = 0;
  int errors = 0;

  dev_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk               (clk),
    .rst               (rst),
    .m0Enable_i        (m0_en),
    .m0Write_i         (1'b0),
    .m0Addr_i          (c_a0),
    .m0DataSave_i      (c_d0),
    .m0ByteSelect_i    (c_b0),
    .m0DataLoad_o      (m0_rdata),
    .m0Busy_o          (m0_busy),
    .m1Enable_i        (m1_en),
    .m1Write_i         (1'b1),
    .m1Addr_i          (c_a1),
    .m1DataSave_i      (c_d1),
    .m1ByteSelect_i    (c_b1),
    .m1DataLoad_o      (m1_rdata),
    .m1Busy_o          (m1_busy),
    .devEnable_o       (dev_en),
    .devWrite_o        (dev_wr),
    .devPhysicalAddr_o (dev_addr),
    .devDataSave_o     (dev_wdata),
    .devByteSelect_o   (dev_be),
    .devDataLoad_i     (c_rd),
    .devBusy_i         (dev_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // own: 0 = idle, 1 = m0, 2 = m1; the owner's enable is assumed high.
  task automatic check_owner(input string tag, input int own);
    check({tag, ".dev_en"},   32'(dev_en),   (own != 0) ? 32'd1 : 32'd0);
    check({tag, ".dev_addr"}, dev_addr,      (own == 1) ? c_a0 : ((own == 2) ? c_a1 : 32'd0));
    check({tag, ".dev_wd"},   dev_wdata,     (own == 1) ? c_d0 : ((own == 2) ? c_d1 : 32'd0));
    check({tag, ".dev_be"},   32'(dev_be),   (own == 1) ? 32'hF : ((own == 2) ? 32'h3 : 32'd0));
    check({tag, ".dev_wr"},   32'(dev_wr),   (own == 2) ? 32'd1 : 32'd0);
    check({tag, ".m0_rd"},    m0_rdata,      (own == 1) ? c_rd : 32'd0);
    check({tag, ".m1_rd"},    m1_rdata,      (own == 2) ? c_rd : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int exp_seq[7];

  initial begin
`ifdef DEV_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 1, 2, 1, 2};
`else
    exp_seq = '{0, 1, 1, 1, 1, 2, 1};
`endif

    // Reset values with m0 already requesting.
    m0_en = 1'b1;
    #2;
    check_owner("rst", 0);
    check("rst.m0_busy", 32'(m0_busy), 32'd1);
    check("rst.m1_busy", 32'(m1_busy), 32'd0);
    check("rst.state",   32'(dut.state_q), 32'd0);
    check("rst.hold",    32'(dut.hold_q),  32'd0);

    // m0-only read: no grant in the release cycle, completion the next.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_owner("rel", 0);
    check("rel.m0_busy", 32'(m0_busy), 32'd1);
    @(negedge clk);
    #1;
    check_owner("rd0", 1);
    check("rd0.m0_busy", 32'(m0_busy), 32'd0);
    @(negedge clk);
    m0_en = 1'b0;

    // Both masters requesting continuously.
    do_reset();
    m0_en = 1'b1;
    m1_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check_owner($sformatf("both%0d", c), exp_seq[c]);
      check($sformatf("both%0d.m0_busy", c), 32'(m0_busy), (exp_seq[c] == 1) ? 32'd0 : 32'd1);
      check($sformatf("both%0d.m1_busy", c), 32'(m1_busy), (exp_seq[c] == 2) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    m0_en = 1'b0;
    m1_en = 1'b0;

    // m1 owns with devBusy high for 5 cycles while m0 waits.
    do_reset();
    m1_en    = 1'b1;
    dev_busy = 1'b1;
    #1;
    check_owner("hold.idle", 0);
    @(negedge clk);
    m0_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check_owner($sformatf("hold%0d", i), 2);
      check($sformatf("hold%0d.m0_busy", i), 32'(m0_busy), 32'd1);
      check($sformatf("hold%0d.m1_busy", i), 32'(m1_busy), 32'd1);
    end
    @(negedge clk);
    dev_busy = 1'b0;
    #1;
    check_owner("hold.done", 2);
    check("hold.done.m1_busy", 32'(m1_busy), 32'd0);
    check("hold.done.m0_busy", 32'(m0_busy), 32'd1);
    @(negedge clk);
    #1;
    check_owner("hold.next", 1);
    check("hold.next.m0_busy", 32'(m0_busy), 32'd0);
    @(negedge clk);
    m0_en = 1'b0;
    m1_en = 1'b0;

    // Owner drops its enable while the device is busy.
    do_reset();
    m0_en    = 1'b1;
    dev_busy = 1'b1;
    @(negedge clk);
    #1;
    check_owner("drop.own", 1);
    check("drop.own.m0_busy", 32'(m0_busy), 32'd1);
    @(negedge clk);
    m0_en = 1'b0;
    #1;
    check("drop.dev_en", 32'(dev_en), 32'd0);
    @(negedge clk);
    #1;
    check_owner("drop.idle", 0);
    check("drop.state", 32'(dut.state_q), 32'd0);
    m0_en = 1'b1;
    @(negedge clk);
    #1;
    check_owner("drop2.own", 1);
    m0_en = 1'b0;
    m1_en = 1'b1;
    @(negedge clk);
    #1;
    check_owner("drop2.m1", 2);
    check("drop2.m1_busy", 32'(m1_busy), 32'd1);

    // Reset asserted mid-transfer after some completions.
    m0_en    = 1'b1;
    dev_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dev_busy = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check_owner("arst", 0);
    check("arst.m0_busy", 32'(m0_busy), 32'd1);
    check("arst.m1_busy", 32'(m1_busy), 32'd1);
    check("arst.state",   32'(dut.state_q), 32'd0);
    check("arst.hold",    32'(dut.hold_q),  32'd0);
    @(negedge clk);
    rst   = 1'b1;
    m0_en = 1'b0;
    m1_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
